chip8_blitter: RTL and testbench

Parametrised sprite/clear engine that offloads the display half of the instruction set from the CPU core: screen clear and XOR sprite draw with collision detection. It adds edge-wrap vs clip mode, 16x16 extended sprites, and a configurable framebuffer size. It sits between the CPU sequencer (command side), main RAM (sprite source) and the framebuffer port (`vram_*`). It performs true read-modify-write against the framebuffer.

---
 rtl/chip8_blitter.sv | 160 ++++++++++++++++
 tb/tb_chip8_blitter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_blitter.sv
// Sprite/clear engine: screen clear and XOR sprite draw with collision, wrap or clip, 8x N or 16x16 sprites.
// Each command performs read-modify-write on the framebuffer; start/clear_start are ignored while busy.
module chip8_blitter #(
  parameter int HRES_BITS   = 7,
  parameter int VRES_BITS   = 6,
  parameter int ADDR_W      = 12,
  parameter int BIG_SPRITES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear_start,
  input  logic [7:0]           spr_x,
  input  logic [7:0]           spr_y,
  input  logic [ADDR_W-1:0]    spr_addr,
  input  logic [3:0]           spr_rows,
  input  logic                 wrap_mode,
  output logic                 busy,
  output logic                 done,
  output logic                 collision,
  output logic [ADDR_W-1:0]    ram_addr,
  input  logic [7:0]           ram_dout,
  output logic [HRES_BITS-1:0] vram_hpos,
  output logic [VRES_BITS-1:0] vram_vpos,
  output logic [1:0]           vram_pixeli,
  input  logic [1:0]           vram_pixelo,
  output logic                 vram_we
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_FETCH_LO, S_LATCH, S_PIX, S_PIX_WR, S_DONE
  } state_t;

  localparam int PXW = HRES_BITS + 5;
  localparam int PYW = VRES_BITS + 5;

  state_t                state, state_nxt;
  logic [HRES_BITS-1:0]  x0, hcnt;
  logic [VRES_BITS-1:0]  y0, vcnt;
  logic [ADDR_W-1:0]     base;
  logic [4:0]            nrows, row, col;
  logic                  big, wrap;
  logic [15:0]           shreg;

  logic [PXW-1:0]        px;
  logic [PYW-1:0]        py;
  logic                  clipped, draw_px, last_col, last_row, adv;
  logic [ADDR_W-1:0]     row_addr;

  logic unused_ok;
  assign unused_ok = &{1'b0, spr_x, spr_y};

  assign px       = PXW'(x0) + PXW'(col);
  assign py       = PYW'(y0) + PYW'(row);
  assign clipped  = !wrap && ((px[PXW-1:HRES_BITS] != '0) || (py[PYW-1:VRES_BITS] != '0));
  assign draw_px  = shreg[15] && !clipped;
  assign last_col = (col == (big ? 5'd15 : 5'd7));
  assign last_row = (row == 5'(nrows - 5'd1));
  assign row_addr = base + (big ? ADDR_W'({row, 1'b0}) : ADDR_W'(row));
  assign adv      = (state == S_PIX && !draw_px) || (state == S_PIX_WR);

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ram_addr    = '0;
    vram_hpos   = '0;
    vram_vpos   = '0;
    vram_pixeli = 2'd0;
    vram_we     = 1'b0;
    case (state)
      S_IDLE: begin
        if (clear_start) state_nxt = S_CLEAR;
        else if (start)  state_nxt = (spr_rows == 4'd0 && BIG_SPRITES == 0) ? S_DONE : S_FETCH;
      end
      S_CLEAR: begin
        vram_hpos = hcnt;
        vram_vpos = vcnt;
        vram_we   = 1'b1;
        if (&hcnt && &vcnt) state_nxt = S_DONE;
      end
      S_FETCH: begin
        ram_addr  = row_addr;
        state_nxt = big ? S_FETCH_LO : S_LATCH;
      end
      S_FETCH_LO: begin
        ram_addr  = row_addr + ADDR_W'(1);
        state_nxt = S_LATCH;
      end
      S_LATCH: state_nxt = S_PIX;
      S_PIX, S_PIX_WR: begin
        if (state == S_PIX_WR || draw_px) begin
          vram_hpos = px[HRES_BITS-1:0];
          vram_vpos = py[VRES_BITS-1:0];
        end
        if (state == S_PIX_WR) begin
          vram_we     = 1'b1;
          vram_pixeli = (vram_pixelo != 2'd0) ? 2'd0 : 2'd3;
        end
        if (state == S_PIX && draw_px) state_nxt = S_PIX_WR;
        else if (last_col)             state_nxt = last_row ? S_DONE : S_FETCH;
        else                           state_nxt = S_PIX;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0 <= '0; y0 <= '0; base <= '0; nrows <= '0; row <= '0; col <= '0;
      big <= 1'b0; wrap <= 1'b0; shreg <= '0; hcnt <= '0; vcnt <= '0;
      collision <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear_start) begin
            hcnt <= '0;
            vcnt <= '0;
          end else if (start) begin
            x0        <= spr_x[HRES_BITS-1:0];
            y0        <= spr_y[VRES_BITS-1:0];
            base      <= spr_addr;
            wrap      <= wrap_mode;
            big       <= (spr_rows == 4'd0);
            nrows     <= (spr_rows == 4'd0) ? 5'd16 : {1'b0, spr_rows};
            row       <= '0;
            col       <= '0;
            collision <= 1'b0;
          end
        end
        S_CLEAR: begin
          hcnt <= hcnt + 1'b1;
          if (&hcnt) vcnt <= vcnt + 1'b1;
        end
        S_FETCH_LO: shreg[15:8] <= ram_dout;
        S_LATCH:    shreg <= big ? {shreg[15:8], ram_dout} : {ram_dout, 8'h00};
        default: ;
      endcase
      if (state == S_PIX_WR && vram_pixelo != 2'd0) collision <= 1'b1;
      // Column advance is shared by skipped pixels and completed writes.
      if (adv) begin
        shreg <= shreg << 1;
        if (last_col) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_chip8_blitter.sv
// Directed bench for chip8_blitter with RAM and framebuffer models and hand-computed expectations.
module tb_chip8_blitter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, clear_start = 1'b0, wrap_mode = 1'b0;
  logic [7:0]  spr_x = '0, spr_y = '0;
  logic [11:0] spr_addr = '0;
  logic [3:0]  spr_rows = '0;
  logic        busy, done, collision, vram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [6:0]  vram_hpos;
  logic [5:0]  vram_vpos;
  logic [1:0]  vram_pixeli, vram_pixelo;

  chip8_blitter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_start(clear_start),
    .spr_x(spr_x), .spr_y(spr_y), .spr_addr(spr_addr), .spr_rows(spr_rows),
    .wrap_mode(wrap_mode), .busy(busy), .done(done), .collision(collision),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .vram_hpos(vram_hpos),
    .vram_vpos(vram_vpos), .vram_pixeli(vram_pixeli), .vram_pixelo(vram_pixelo),
    .vram_we(vram_we)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] mem [0:4095];
  logic [1:0] fb  [0:63][0:127];
  logic       fill_req = 1'b0;
  logic [1:0] fill_val = 2'd0;
  logic [11:0] addr_log [$];

  always @(posedge clk) begin
    ram_dout    <= mem[ram_addr];
    vram_pixelo <= fb[vram_vpos][vram_hpos];
    if (fill_req) begin
      for (int yy = 0; yy < 64; yy++)
        for (int xx = 0; xx < 128; xx++)
          fb[yy][xx] <= fill_val;
    end else if (vram_we) begin
      fb[vram_vpos][vram_hpos] <= vram_pixeli;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lit_count();
    int n = 0;
    for (int yy = 0; yy < 64; yy++)
      for (int xx = 0; xx < 128; xx++)
        if (fb[yy][xx] != 2'd0) n++;
    return n;
  endfunction

  task automatic fill(input logic [1:0] v);
    fill_val = v;
    fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_clear(output int lat);
    int t0;
    clear_start = 1'b1;
    t0 = cyc;
    lat = -1;
    @(negedge clk);
    clear_start = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      if (done) begin lat = cyc - t0; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // poke re-pulses start with different parameters while the draw is running.
  task automatic draw(input int x, input int y, input int addr, input int rows,
                      input bit wrap, input bit poke, output int lat, output bit done_low);
    int t0;
    spr_x = 8'(x); spr_y = 8'(y); spr_addr = 12'(addr);
    spr_rows = 4'(rows); wrap_mode = wrap;
    addr_log.delete();
    start = 1'b1;
    t0 = cyc;
    lat = -1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin lat = cyc - t0; break; end
      if (busy && ram_addr != 12'h000) addr_log.push_back(ram_addr);
      if (poke && i == 4) begin
        start = 1'b1; spr_x = 8'd50; spr_addr = 12'h202; spr_rows = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    done_low = !done;
  endtask

  initial begin
    int lat, bad, dcount;
    bit dl;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h200] = 8'h80;
    mem[12'h201] = 8'h01;
    mem[12'h202] = 8'hFF;
    for (int i = 0; i < 32; i++) mem[12'h300 + i] = 8'hFF;

    fill_val = 2'd3; fill_req = 1'b1;
    repeat (2) @(negedge clk);
    fill_req = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_coll", collision, 0);
    chk("rst_we", vram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_hpos", vram_hpos, 0);
    chk("rst_vpos", vram_vpos, 0);
    chk("rst_pixeli", vram_pixeli, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_clear(lat);
    chk("clr_lat", lat, 8193);
    chk("clr_count", lit_count(), 0);
    chk("clr_coll", collision, 0);

    draw(0, 0, 'h200, 1, 0, 0, lat, dl);
    chk("d1_lat", lat, 12);
    chk("d1_done_pulse", dl, 1);
    chk("d1_px", fb[0][0], 3);
    chk("d1_count", lit_count(), 1);
    chk("d1_coll", collision, 0);

    draw(0, 0, 'h200, 1, 0, 0, lat, dl);
    chk("d2_lat", lat, 12);
    chk("d2_px", fb[0][0], 0);
    chk("d2_count", lit_count(), 0);
    chk("d2_coll", collision, 1);

    draw(10, 10, 'h201, 1, 0, 0, lat, dl);
    chk("d3_lat", lat, 12);
    chk("d3_px", fb[10][17], 3);
    chk("d3_coll", collision, 0);

    fill(2'd0);
    draw(124, 0, 'h202, 1, 0, 0, lat, dl);
    chk("clip_lat", lat, 15);
    chk("clip_count", lit_count(), 4);
    chk("clip_124", fb[0][124], 3);
    chk("clip_127", fb[0][127], 3);
    chk("clip_0", fb[0][0], 0);

    fill(2'd0);
    draw(124, 0, 'h202, 1, 1, 0, lat, dl);
    chk("wrap_lat", lat, 19);
    chk("wrap_count", lit_count(), 8);
    chk("wrap_0", fb[0][0], 3);
    chk("wrap_3", fb[0][3], 3);
    chk("wrap_4", fb[0][4], 0);
    chk("wrap_coll", collision, 0);

    fill(2'd0);
    draw(120, 60, 'h300, 0, 1, 0, lat, dl);
    chk("big_lat", lat, 561);
    chk("big_count", lit_count(), 256);
    chk("big_nreads", addr_log.size(), 32);
    bad = 0;
    for (int i = 0; i < addr_log.size() && i < 32; i++)
      if (addr_log[i] != 12'(12'h300 + i)) bad++;
    chk("big_read_order", bad, 0);
    chk("big_origin", fb[60][120], 3);
    chk("big_far", fb[11][7], 3);
    chk("big_outside", fb[12][8], 0);
    chk("big_coll", collision, 0);

    fill(2'd0);
    draw(0, 0, 'h200, 1, 0, 1, lat, dl);
    chk("poke_lat", lat, 12);
    chk("poke_count", lit_count(), 1);
    chk("poke_px", fb[0][0], 3);
    chk("poke_idle", busy, 0);

    spr_x = 8'd0; spr_y = 8'd0; spr_addr = 12'h202; spr_rows = 4'd1; wrap_mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_coll", collision, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_we", vram_we, 0);
    chk("arst_coll", collision, 0);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("arst_no_done", dcount, 0);
    chk("arst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
